// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the seg_scan display scanner.
// Optional blank interval between digits: SEG_SCAN_BLANK_EN.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ON    = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width that can hold 0..n-1, never below one bit
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_scan_div.sv
// Terminal-count interval counter shared by the dwell and blank phases.
// Counts up from zero; tc flags the cycle where cnt equals tc_val.
module seg_scan_div #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 7-segment scanner: one shared bus, one-hot active-low digits.
// Define SEG_SCAN_BLANK_EN to insert BLANK_CYC dark cycles between digits.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int NUM_SEG   = 6,
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [7:0]         seg [0:NUM_SEG-1],
    output logic [7:0]         seg_out,
    output logic [NUM_SEG-1:0] dig_n,
    output logic               frame_tick
);

    localparam int DWELL = CLK_HZ / (SCAN_HZ * NUM_SEG);
`ifdef SEG_SCAN_BLANK_EN
    localparam int CW = cnt_w(max_int(DWELL, BLANK_CYC));
`else
    localparam int CW = cnt_w(DWELL);
`endif
    localparam int IW = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

    localparam logic [CW-1:0]      DWELL_TC = CW'(DWELL - 1);
    localparam logic [IW-1:0]      LAST     = IW'(NUM_SEG - 1);
    localparam logic [NUM_SEG-1:0] ONE      = NUM_SEG'(1);

    generate
        if (DWELL < 2) begin : g_dwell_chk
            $error("seg_scan: DWELL must be at least 2");
        end
`ifdef SEG_SCAN_BLANK_EN
        if (BLANK_CYC < 1) begin : g_blank_chk
            $error("seg_scan: BLANK_CYC must be at least 1");
        end
`endif
    endgenerate

    scan_state_e        state;
    scan_state_e        state_n;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      idx_n;
    logic [IW-1:0]      idx_nx;
    logic [7:0]         seg_n;
    logic [NUM_SEG-1:0] dig_n_n;
    logic               ft_n;
    logic               cnt_clr;
    logic               cnt_inc;
    logic               tc;
    logic [CW-1:0]      tc_val;

`ifdef SEG_SCAN_BLANK_EN
    localparam logic [CW-1:0] BLANK_TC = CW'(BLANK_CYC - 1);
    assign tc_val = (state == BLANK) ? BLANK_TC : DWELL_TC;
`else
    assign tc_val = DWELL_TC;
`endif

    assign idx_nx = (idx == LAST) ? '0 : idx + 1'b1;

    seg_scan_div #(
        .W(CW)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .tc_val(tc_val),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (!en) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: state_n = ON;
`ifdef SEG_SCAN_BLANK_EN
                ON:    state_n = tc ? BLANK : ON;
                BLANK: state_n = tc ? ON : BLANK;
`else
                ON:    state_n = ON;
                BLANK: state_n = IDLE;
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    // Digit loads take idx_nx; the wrap from the last digit raises frame_tick
    always_comb begin
        idx_n   = idx;
        seg_n   = seg_out;
        dig_n_n = dig_n;
        ft_n    = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (!en) begin
            idx_n   = '0;
            seg_n   = SEG_OFF;
            dig_n_n = '1;
            cnt_clr = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    idx_n   = '0;
                    seg_n   = seg[0];
                    dig_n_n = ~ONE;
                    cnt_clr = 1'b1;
                end
                ON: begin
                    if (tc) begin
                        cnt_clr = 1'b1;
`ifdef SEG_SCAN_BLANK_EN
                        seg_n   = SEG_OFF;
                        dig_n_n = '1;
`else
                        idx_n   = idx_nx;
                        seg_n   = seg[idx_nx];
                        dig_n_n = ~(ONE << idx_nx);
                        ft_n    = (idx == LAST);
`endif
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                BLANK: begin
                    if (tc) begin
                        cnt_clr = 1'b1;
                        idx_n   = idx_nx;
                        seg_n   = seg[idx_nx];
                        dig_n_n = ~(ONE << idx_nx);
                        ft_n    = (idx == LAST);
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    idx_n   = '0;
                    seg_n   = SEG_OFF;
                    dig_n_n = '1;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            seg_out    <= SEG_OFF;
            dig_n      <= '1;
            frame_tick <= 1'b0;
        end else begin
            idx        <= idx_n;
            seg_out    <= seg_n;
            dig_n      <= dig_n_n;
            frame_tick <= ft_n;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: DWELL=10 with six digits.
// Blank-interval expectations are selected by SEG_SCAN_BLANK_EN.
module tb_seg_scan;

    localparam int NUM_SEG = 6;
`ifdef SEG_SCAN_BLANK_EN
    localparam int FRAME = 84;
`else
    localparam int FRAME = 60;
`endif
    localparam int T_END = 2 * FRAME + 5;
    localparam int NV    = 12;

    typedef struct {
        int         t;
        logic [7:0] so;
        logic [5:0] dn;
        logic       ft;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] seg [0:NUM_SEG-1];
    logic [7:0] seg_out;
    logic [5:0] dig_n;
    logic       frame_tick;

    int passed = 0;
    int total  = 0;

    seg_scan #(
        .NUM_SEG  (NUM_SEG),
        .CLK_HZ   (6000),
        .SCAN_HZ  (100),
        .BLANK_CYC(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .seg       (seg),
        .seg_out   (seg_out),
        .dig_n     (dig_n),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_dig(input logic [5:0] pat, input int lim,
                            output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (dig_n == pat) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    vec_t vt [NV];
    int   ticks;
    int   first_tick;
    int   last_tick;
    int   per_err;
    int   multi;
    int   n;
    bit   ok;

    initial begin
`ifdef SEG_SCAN_BLANK_EN
        vt[0]  = '{0,  8'h10, 6'h3E, 1'b0};
        vt[1]  = '{9,  8'h10, 6'h3E, 1'b0};
        vt[2]  = '{10, 8'hFF, 6'h3F, 1'b0};
        vt[3]  = '{13, 8'hFF, 6'h3F, 1'b0};
        vt[4]  = '{14, 8'h11, 6'h3D, 1'b0};
        vt[5]  = '{23, 8'h11, 6'h3D, 1'b0};
        vt[6]  = '{24, 8'hFF, 6'h3F, 1'b0};
        vt[7]  = '{28, 8'h12, 6'h3B, 1'b0};
        vt[8]  = '{79, 8'h15, 6'h1F, 1'b0};
        vt[9]  = '{80, 8'hFF, 6'h3F, 1'b0};
        vt[10] = '{84, 8'h10, 6'h3E, 1'b1};
        vt[11] = '{85, 8'h10, 6'h3E, 1'b0};
`else
        vt[0]  = '{0,   8'h10, 6'h3E, 1'b0};
        vt[1]  = '{9,   8'h10, 6'h3E, 1'b0};
        vt[2]  = '{10,  8'h11, 6'h3D, 1'b0};
        vt[3]  = '{19,  8'h11, 6'h3D, 1'b0};
        vt[4]  = '{20,  8'h12, 6'h3B, 1'b0};
        vt[5]  = '{35,  8'h13, 6'h37, 1'b0};
        vt[6]  = '{45,  8'h14, 6'h2F, 1'b0};
        vt[7]  = '{59,  8'h15, 6'h1F, 1'b0};
        vt[8]  = '{60,  8'h10, 6'h3E, 1'b1};
        vt[9]  = '{61,  8'h10, 6'h3E, 1'b0};
        vt[10] = '{70,  8'h11, 6'h3D, 1'b0};
        vt[11] = '{120, 8'h10, 6'h3E, 1'b1};
`endif
        for (int i = 0; i < NUM_SEG; i++) seg[i] = 8'h10 + 8'(i);
        rst_n = 1'b0;
        en    = 1'b0;
        step();
        step();
        check("rst_seg_out", 32'(seg_out), 32'hFF);
        check("rst_dig_n", 32'(dig_n), 32'h3F);
        check("rst_tick", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;
        step();
        step();
        step();
        check("idle_dark", 32'(dig_n), 32'h3F);

        // Frames from enable: t=0 is the first edge sampling en=1
        en = 1'b1;
        step();
        ticks = 0;
        first_tick = -1;
        last_tick = -1;
        per_err = 0;
        multi = 0;
        for (int t = 0; t <= T_END; t++) begin
            if (t > 0) step();
            if ($countones(~dig_n) > 1) multi++;
            if (frame_tick) begin
                if (last_tick >= 0 && t - last_tick != FRAME) per_err++;
                if (first_tick < 0) first_tick = t;
                last_tick = t;
                ticks++;
            end
            for (int v = 0; v < NV; v++) begin
                if (vt[v].t == t) begin
                    check($sformatf("vec%0d_seg_out", v), 32'(seg_out),
                          32'(vt[v].so));
                    check($sformatf("vec%0d_dig_n", v), 32'(dig_n),
                          32'(vt[v].dn));
                    check($sformatf("vec%0d_tick", v), 32'(frame_tick),
                          32'(vt[v].ft));
                end
            end
        end
        check("tick_count", 32'(ticks), 32'd2);
        check("tick_first", 32'(first_tick), 32'(FRAME));
        check("tick_period", 32'(per_err), 32'd0);
        check("one_hot", 32'(multi), 32'd0);

        // Mid-dwell input change must wait for the next load of digit 2
        wait_dig(6'h3B, 200, ok);
        check("wait_dig2", 32'(ok), 32'd1);
        seg[2] = 8'hAA;
        n = 0;
        while (dig_n == 6'h3B && n < 30) begin
            check("dig2_hold", 32'(seg_out), 32'h12);
            step();
            n++;
        end
        wait_dig(6'h3B, 200, ok);
        check("wait_dig2_again", 32'(ok), 32'd1);
        check("dig2_new", 32'(seg_out), 32'hAA);
        seg[2] = 8'h12;

        // Enable drop mid-dwell on digit 3
        wait_dig(6'h37, 200, ok);
        check("wait_dig3", 32'(ok), 32'd1);
        step();
        step();
        step();
        en = 1'b0;
        step();
        check("abort_seg_out", 32'(seg_out), 32'hFF);
        check("abort_dig_n", 32'(dig_n), 32'h3F);
        check("abort_tick", 32'(frame_tick), 32'h0);
        step();
        check("abort_stay", 32'(dig_n), 32'h3F);
        en = 1'b1;
        step();
        check("restart_seg_out", 32'(seg_out), 32'h10);
        check("restart_dig_n", 32'(dig_n), 32'h3E);
        check("restart_tick", 32'(frame_tick), 32'h0);
        step();
        check("restart_tick2", 32'(frame_tick), 32'h0);

        // Asynchronous reset between edges
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_seg_out", 32'(seg_out), 32'hFF);
        check("async_dig_n", 32'(dig_n), 32'h3F);
        check("async_tick", 32'(frame_tick), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rel_seg_out", 32'(seg_out), 32'h10);
        check("rel_dig_n", 32'(dig_n), 32'h3E);
        for (int i = 0; i < 10; i++) step();
`ifdef SEG_SCAN_BLANK_EN
        check("rel_adv", 32'(seg_out), 32'hFF);
`else
        check("rel_adv", 32'(seg_out), 32'h11);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
